// File: rtl/pemstat_cntr_bank_if.sv
// Statistics bank bus: event pulses and frame length in, host read port and overflow interrupt out.
interface pemstat_cntr_bank_if;
    logic [43:0] stat_inc;
    logic [15:0] frm_len;
    logic        stat_clr;
    logic        rd_req;
    logic [5:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_ack;
    logic        ovf_irq;

    modport master (
        output stat_inc, frm_len, stat_clr, rd_req, rd_addr,
        input  rd_data, rd_ack, ovf_irq
    );

    modport slave (
        input  stat_inc, frm_len, stat_clr, rd_req, rd_addr,
        output rd_data, rd_ack, ovf_irq
    );
endinterface

// File: rtl/pemstat_cntr_bank.sv
// Bank of 44 event counters plus RX/TX octet accumulators with sticky overflow flags
// and a single-cycle-latency host read port with optional clear-on-read.
module pemstat_cntr_bank #(
    parameter int SATURATE  = 0,
    parameter int CLR_ON_RD = 1
) (
    input logic clk,
    input logic rstn,
    pemstat_cntr_bank_if.slave bus
);
    localparam int NumCnt = 46;

    logic [31:0]       cnt_q [NumCnt];
    logic [31:0]       cnt_d [NumCnt];
    logic [NumCnt-1:0] ovf_q;
    logic [NumCnt-1:0] ovf_d;
    logic [31:0]       rdData_q;
    logic [31:0]       rdData_d;
    logic              rdAck_q;
    logic              ovfIrq_q;

    logic [NumCnt-1:0] incVec;
    logic              rdHit;
    logic [31:0]       base;
    logic [32:0]       amt;
    logic [32:0]       sum;

    // Octet accumulators ride on the RX (bit 7) and TX (bit 24) good-frame events.
    assign incVec = {bus.stat_inc[24], bus.stat_inc[7], bus.stat_inc};

    always_comb begin
        rdData_d = rdData_q;
        if (bus.rd_req) begin
            rdData_d = '0;
            for (int k = 0; k < NumCnt; k++) begin
                if (bus.rd_addr == 6'(k)) begin
                    rdData_d = cnt_q[k];
                end
            end
        end

        rdHit = 1'b0;
        base  = '0;
        amt   = '0;
        sum   = '0;
        for (int k = 0; k < NumCnt; k++) begin
            rdHit = bus.rd_req && (bus.rd_addr == 6'(k));
            // A clear-on-read folds into the base so a coincident increment survives.
            base  = (rdHit && (CLR_ON_RD != 0)) ? 32'd0 : cnt_q[k];
            if (!incVec[k]) begin
                amt = 33'd0;
            end else if (k < 44) begin
                amt = 33'd1;
            end else begin
                amt = {17'd0, bus.frm_len};
            end
            sum      = {1'b0, base} + amt;
            cnt_d[k] = (sum[32] && (SATURATE != 0)) ? 32'hFFFF_FFFF : sum[31:0];
            ovf_d[k] = (ovf_q[k] && !rdHit) || sum[32];
            if (bus.stat_clr) begin
                cnt_d[k] = '0;
                ovf_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q    <= '{default: '0};
            ovf_q    <= '0;
            rdData_q <= '0;
            rdAck_q  <= 1'b0;
            ovfIrq_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            rdData_q <= rdData_d;
            rdAck_q  <= bus.rd_req;
            ovfIrq_q <= |ovf_q;
        end
    end

    assign bus.rd_data = rdData_q;
    assign bus.rd_ack  = rdAck_q;
    assign bus.ovf_irq = ovfIrq_q;
endmodule

// File: tb/tb_pemstat_cntr_bank.sv
// Directed bench for pemstat_cntr_bank: a wrapping/clear-on-read instance and a
// saturating/non-clearing instance share one stimulus stream.
module tb_pemstat_cntr_bank;
    logic clk;
    logic rstn;
    int   checkCount;
    int   passCount;

    pemstat_cntr_bank_if busIf ();
    pemstat_cntr_bank_if satIf ();

    assign satIf.stat_inc = busIf.stat_inc;
    assign satIf.frm_len  = busIf.frm_len;
    assign satIf.stat_clr = busIf.stat_clr;
    assign satIf.rd_req   = busIf.rd_req;
    assign satIf.rd_addr  = busIf.rd_addr;

    pemstat_cntr_bank #(.SATURATE(0), .CLR_ON_RD(1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (busIf.slave)
    );

    pemstat_cntr_bank #(.SATURATE(1), .CLR_ON_RD(0)) dutSat (
        .clk  (clk),
        .rstn (rstn),
        .bus  (satIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [43:0] inc, input logic [15:0] len,
                                 input logic clr, input logic req, input logic [5:0] addr);
        busIf.stat_inc = inc;
        busIf.frm_len  = len;
        busIf.stat_clr = clr;
        busIf.rd_req   = req;
        busIf.rd_addr  = addr;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [43:0] bitOf(input int k);
        logic [43:0] v;
        v = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    // Issue one read, hold it for one edge, and compare both instances.
    task automatic readBoth(input string tag, input logic [5:0] addr,
                            input logic [31:0] expWrap, input logic [31:0] expSat);
        applyStimulus('0, 16'd0, 1'b0, 1'b1, addr);
        cyc(1);
        checkOutput({tag, "_ack"}, {31'd0, busIf.rd_ack}, 32'd1);
        checkOutput({tag, "_wrap"}, busIf.rd_data, expWrap);
        checkOutput({tag, "_sat"}, satIf.rd_data, expSat);
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;

        // Reset overrides a pending read, a clear and every event bit.
        rstn = 1'b0;
        applyStimulus('1, 16'd1518, 1'b1, 1'b1, 6'd0);
        cyc(2);
        checkOutput("rst_ack", {31'd0, busIf.rd_ack}, 32'd0);
        checkOutput("rst_data", busIf.rd_data, 32'd0);
        checkOutput("rst_irq", {31'd0, busIf.ovf_irq}, 32'd0);
        checkOutput("rst_sat_irq", {31'd0, satIf.ovf_irq}, 32'd0);

        // First increment lands on the first edge with reset released.
        rstn = 1'b1;
        applyStimulus(bitOf(3), 16'd0, 1'b0, 1'b0, 6'd0);
        cyc(5);
        checkOutput("no_ack_after_rst", {31'd0, busIf.rd_ack}, 32'd0);

        // Back-to-back reads of counter 3: second read sees the clear in the wrapping instance.
        applyStimulus('0, 16'd0, 1'b0, 1'b1, 6'd3);
        cyc(1);
        checkOutput("rd3_ack", {31'd0, busIf.rd_ack}, 32'd1);
        checkOutput("rd3_wrap", busIf.rd_data, 32'd5);
        checkOutput("rd3_sat", satIf.rd_data, 32'd5);
        cyc(1);
        checkOutput("rerd3_ack", {31'd0, busIf.rd_ack}, 32'd1);
        checkOutput("rerd3_wrap", busIf.rd_data, 32'd0);
        checkOutput("rerd3_sat", satIf.rd_data, 32'd5);
        applyStimulus('0, 16'd0, 1'b0, 1'b0, 6'd3);
        cyc(1);
        checkOutput("idle_ack", {31'd0, busIf.rd_ack}, 32'd0);
        checkOutput("hold_sat", satIf.rd_data, 32'd5);

        // RX octets from three 1518-byte frames; TX octets plus a parallel event.
        applyStimulus(bitOf(7), 16'd1518, 1'b0, 1'b0, 6'd0);
        cyc(3);
        applyStimulus(bitOf(24) | bitOf(5), 16'd64, 1'b0, 1'b0, 6'd0);
        cyc(2);
        readBoth("rd44", 6'd44, 32'd4554, 32'd4554);
        readBoth("rd7", 6'd7, 32'd3, 32'd3);
        readBoth("rd45", 6'd45, 32'd128, 32'd128);
        readBoth("rd5", 6'd5, 32'd2, 32'd2);
        readBoth("rd24", 6'd24, 32'd2, 32'd2);

        // Read coinciding with an increment of the same counter.
        applyStimulus(bitOf(2), 16'd0, 1'b0, 1'b0, 6'd0);
        cyc(9);
        applyStimulus(bitOf(2), 16'd0, 1'b0, 1'b1, 6'd2);
        cyc(1);
        checkOutput("rdinc2_wrap", busIf.rd_data, 32'd9);
        checkOutput("rdinc2_sat", satIf.rd_data, 32'd9);
        readBoth("after2", 6'd2, 32'd1, 32'd10);

        applyStimulus(bitOf(7), 16'd200, 1'b0, 1'b1, 6'd44);
        cyc(1);
        checkOutput("rdinc44_wrap", busIf.rd_data, 32'd0);
        checkOutput("rdinc44_sat", satIf.rd_data, 32'd4554);
        readBoth("after44", 6'd44, 32'd200, 32'd4754);

        // Clear with a coincident increment and a coincident read of the pre-clear value.
        applyStimulus(bitOf(0), 16'd0, 1'b1, 1'b1, 6'd7);
        cyc(1);
        checkOutput("clr_ack", {31'd0, busIf.rd_ack}, 32'd1);
        checkOutput("clr_rd7_wrap", busIf.rd_data, 32'd1);
        checkOutput("clr_rd7_sat", satIf.rd_data, 32'd4);
        readBoth("clr_rd0", 6'd0, 32'd0, 32'd0);
        readBoth("clr_rd7", 6'd7, 32'd0, 32'd0);

        // Overflow of counter 10 from a preloaded all-ones value.
        applyStimulus('0, 16'd0, 1'b0, 1'b0, 6'd0);
        dut.cnt_q[10]    = 32'hFFFF_FFFF;
        dutSat.cnt_q[10] = 32'hFFFF_FFFF;
        applyStimulus(bitOf(10), 16'd0, 1'b0, 1'b0, 6'd0);
        cyc(1);
        applyStimulus('0, 16'd0, 1'b0, 1'b0, 6'd0);
        cyc(1);
        checkOutput("ovf_irq_wrap", {31'd0, busIf.ovf_irq}, 32'd1);
        checkOutput("ovf_irq_sat", {31'd0, satIf.ovf_irq}, 32'd1);
        readBoth("ovf_rd10", 6'd10, 32'd0, 32'hFFFF_FFFF);
        applyStimulus('0, 16'd0, 1'b0, 1'b0, 6'd0);
        checkOutput("irq_lag", {31'd0, busIf.ovf_irq}, 32'd1);
        cyc(1);
        checkOutput("irq_clr_wrap", {31'd0, busIf.ovf_irq}, 32'd0);
        checkOutput("irq_clr_sat", {31'd0, satIf.ovf_irq}, 32'd0);

        // Saturated counter overflows again while being read: its flag must stay set.
        applyStimulus(bitOf(10), 16'd0, 1'b0, 1'b1, 6'd10);
        cyc(1);
        checkOutput("rdovf_wrap", busIf.rd_data, 32'd0);
        checkOutput("rdovf_sat", satIf.rd_data, 32'hFFFF_FFFF);
        applyStimulus('0, 16'd0, 1'b0, 1'b0, 6'd0);
        cyc(2);
        checkOutput("rdovf_irq_wrap", {31'd0, busIf.ovf_irq}, 32'd0);
        checkOutput("rdovf_irq_sat", {31'd0, satIf.ovf_irq}, 32'd1);
        readBoth("sat_hold10", 6'd10, 32'd1, 32'hFFFF_FFFF);

        // Unmapped address reads zero but still acks.
        readBoth("rd50", 6'd50, 32'd0, 32'd0);

        // Reset while a read is in flight.
        applyStimulus(bitOf(1), 16'd0, 1'b0, 1'b0, 6'd0);
        cyc(2);
        rstn = 1'b0;
        applyStimulus('0, 16'd0, 1'b0, 1'b1, 6'd1);
        cyc(1);
        checkOutput("midrst_ack", {31'd0, busIf.rd_ack}, 32'd0);
        checkOutput("midrst_irq_sat", {31'd0, satIf.ovf_irq}, 32'd0);
        rstn = 1'b1;
        applyStimulus('0, 16'd0, 1'b0, 1'b0, 6'd0);
        cyc(1);
        checkOutput("postrst_ack", {31'd0, busIf.rd_ack}, 32'd0);
        readBoth("postrst_rd1", 6'd1, 32'd0, 32'd0);
        readBoth("postrst_rd44", 6'd44, 32'd0, 32'd0);
        readBoth("postrst_rd10", 6'd10, 32'd0, 32'd0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
